pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_entry_reg.sv | 55 +++++
 rtl/pipe_stage_reg.sv | 153 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the ready/valid pipeline stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  localparam int CTRL_W_DEF = 12;
  localparam int DATA_W_DEF = 192;

endpackage

// File: rtl/pipe_entry_reg.sv
// One valid+ctrl+data holding register.
// Clear drops the entry and zeroes ctrl; data is left alone.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              ld_valid,
  input  logic [CTRL_W-1:0] ld_ctrl,
  input  logic [DATA_W-1:0] ld_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (load) begin
      valid_d = ld_valid;
      ctrl_d  = ld_ctrl;
      data_d  = ld_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign ctrl  = ctrl_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Ready/valid pipeline stage register with optional skid entry.
// Outputs come only from the main entry; skid refills it.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  localparam bit HAS_SKID = (SKID != 0);

  pipe_state_e state_q, state_d;
  logic        in_ready_q, in_ready_d;

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic main_load, main_clr, main_from_skid;
  logic skid_load, skid_clr;
  logic xfer_in, xfer_out;

  logic              mld_valid;
  logic [CTRL_W-1:0] mld_ctrl;
  logic [DATA_W-1:0] mld_data;

  assign in_ready = HAS_SKID ? in_ready_q
                             : (out_ready | ~main_valid);
  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = main_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d   = BUSY;
            main_load = 1'b1;
          end
        end
        BUSY: begin
          unique case (1'b1)
            xfer_in && xfer_out: begin
              main_load = 1'b1;
            end
            xfer_out && !xfer_in: begin
              state_d  = EMPTY;
              main_clr = 1'b1;
            end
            xfer_in && !xfer_out: begin
              if (HAS_SKID) begin
                state_d   = FULL;
                skid_load = 1'b1;
              end
            end
            default: ;
          endcase
        end
        FULL: begin
          if (xfer_out) begin
            state_d        = BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    mld_valid = 1'b1;
    mld_ctrl  = in_ctrl;
    mld_data  = in_data;
    if (main_from_skid) begin
      mld_valid = skid_valid;
      mld_ctrl  = skid_ctrl;
      mld_data  = skid_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  pipe_entry_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_main (
    .clock   (clock),
    .reset   (reset),
    .clear   (main_clr),
    .load    (main_load),
    .ld_valid(mld_valid),
    .ld_ctrl (mld_ctrl),
    .ld_data (mld_data),
    .valid   (main_valid),
    .ctrl    (main_ctrl),
    .data    (main_data)
  );

  pipe_entry_reg #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) u_skid (
    .clock   (clock),
    .reset   (reset),
    .clear   (skid_clr),
    .load    (skid_load),
    .ld_valid(1'b1),
    .ld_ctrl (in_ctrl),
    .ld_data (in_data),
    .valid   (skid_valid),
    .ctrl    (skid_ctrl),
    .data    (skid_data)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=0 and SKID=1 instances
// checked against a per-instance FIFO scoreboard.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = 12;
  localparam int DW = 192;
  localparam int W  = CW + DW;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, flush;
  logic          iv   [2];
  logic          ordy [2];
  logic [CW-1:0] ic   [2];
  logic [DW-1:0] id   [2];

  logic          ir0, ir1, ov0, ov1;
  logic [CW-1:0] oc0, oc1;
  logic [DW-1:0] od0, od1;

  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  int acc [2];
  int got [2];
  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (iv[0]),
    .in_ready (ir0),
    .in_ctrl  (ic[0]),
    .in_data  (id[0]),
    .out_valid(ov0),
    .out_ready(ordy[0]),
    .out_ctrl (oc0),
    .out_data (od0)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .in_valid (iv[1]),
    .in_ready (ir1),
    .in_ctrl  (ic[1]),
    .in_data  (id[1]),
    .out_valid(ov1),
    .out_ready(ordy[1]),
    .out_ctrl (oc1),
    .out_data (od1)
  );

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input int k);
    logic          r, v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [W-1:0]  e;
    int            n;
    if (k == 0) begin
      r = ir0; v = ov0; c = oc0; d = od0; n = q0.size();
    end else begin
      r = ir1; v = ov1; c = oc1; d = od1; n = q1.size();
    end
    if (reset) begin
      if (k == 0) q0.delete(); else q1.delete();
      return;
    end
    check($sformatf("occ%0d", k), v, n != 0);
    if (!v) check($sformatf("ctrl_idle%0d", k), c, 0);
    if (k == 1) check("rdy_skid", r, n < 2);
    else        check("rdy_comb", r, ordy[0] || n == 0);
    if (v && ordy[k]) begin
      if (n == 0) begin
        check($sformatf("underflow%0d", k), 1, 0);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("out%0d", k), {c, d}, e);
        got[k]++;
      end
    end
    if (flush) begin
      if (k == 0) q0.delete(); else q1.delete();
    end else if (iv[k] && r) begin
      if (k == 0) q0.push_back({ic[0], id[0]});
      else        q1.push_back({ic[1], id[1]});
      acc[k]++;
    end
  endtask

  task automatic cyc();
    #2;
    sample(0);
    sample(1);
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] rdata();
    return {$urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int cycles;
    reset = 1'b1;
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0;
      ic[k] = '0;   id[k] = '0;
      acc[k] = 0;   got[k] = 0;
    end
    @(posedge clock);
    #1;
    cyc();
    reset = 1'b0;
    check("rst_valid0", ov0, 0);
    check("rst_valid1", ov1, 0);
    check("rst_ctrl1", oc1, 0);
    check("rst_data0", od0, 0);
    check("rst_data1", od1, 0);
    check("rst_rdy1", ir1, 1);

    // first transfer, one-cycle latency
    iv[1] = 1'b1; ic[1] = 12'hABC; id[1] = rdata(); ordy[1] = 1'b1;
    cyc();
    iv[1] = 1'b0;
    check("lat_valid", ov1, 1);
    check("lat_ctrl", oc1, 12'hABC);
    check("lat_rdy", ir1, 1);
    cyc();

    // fill skid, then drain in order
    ordy[1] = 1'b0;
    iv[1] = 1'b1; ic[1] = 12'd1; id[1] = rdata();
    cyc();
    ic[1] = 12'd2; id[1] = rdata();
    cyc();
    iv[1] = 1'b0;
    check("full_rdy", ir1, 0);
    check("full_ctrl", oc1, 1);
    check("full_valid", ov1, 1);
    ordy[1] = 1'b1;
    cyc();
    check("drain_ctrl", oc1, 2);
    check("drain_rdy", ir1, 1);
    cyc();
    check("drain_empty", ov1, 0);

    // flush while full with a simultaneous push
    ordy[1] = 1'b0;
    iv[1] = 1'b1; ic[1] = 12'd1; id[1] = rdata();
    cyc();
    ic[1] = 12'd2; id[1] = rdata();
    cyc();
    ic[1] = 12'd3; id[1] = rdata(); flush = 1'b1;
    cyc();
    flush = 1'b0; iv[1] = 1'b0;
    check("flush_valid", ov1, 0);
    check("flush_ctrl", oc1, 0);
    ordy[1] = 1'b1;
    cyc();
    cyc();
    check("flush_gone", ov1, 0);

    // reset while holding a stalled entry
    ordy[1] = 1'b0;
    iv[1] = 1'b1; ic[1] = 12'd5; id[1] = rdata();
    cyc();
    iv[1] = 1'b0;
    check("busy_valid", ov1, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_mid_valid", ov1, 0);
    check("rst_mid_data", od1, 0);
    check("rst_mid_rdy", ir1, 1);

    // SKID=0: in_ready follows out_ready combinationally
    ordy[0] = 1'b0;
    iv[0] = 1'b1; ic[0] = CW'($urandom); id[0] = rdata();
    cyc();
    for (int i = 0; i < 8; i++) begin
      ordy[0] = i[0];
      ic[0] = CW'($urandom); id[0] = rdata();
      #1;
      check("rdy_follow", ir0, ordy[0]);
      check("hold_valid0", ov0, 1);
      cyc();
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    cyc();
    cyc();

    // random streams, 100 entries per instance
    for (int k = 0; k < 2; k++) begin
      acc[k] = 0; got[k] = 0;
    end
    cycles = 0;
    while (!(acc[0] == 100 && got[0] == 100 &&
             acc[1] == 100 && got[1] == 100) && cycles < 4000) begin
      for (int k = 0; k < 2; k++) begin
        if (acc[k] < 100) begin
          iv[k] = 1'($urandom_range(0, 1));
          ic[k] = CW'($urandom);
          id[k] = rdata();
        end else begin
          iv[k] = 1'b0;
        end
        ordy[k] = ($urandom_range(0, 3) != 0);
      end
      cyc();
      cycles++;
    end
    check("stream_timeout", cycles < 4000, 1);
    check("stream_cnt0", got[0], 100);
    check("stream_cnt1", got[1], 100);
    check("stream_left0", q0.size(), 0);
    check("stream_left1", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
